// File: rtl/fire_button_trigger_pkg.sv
// fire_trigger_pkg: shared FSM state type and default timing constants for fire_button_trigger
package fire_trigger_pkg;
   typedef enum logic [1:0] {IDLE, PRESSED, COOLDOWN} state_t;
   localparam int DEF_DEBOUNCE_CYCLES = 1_000_000;
   localparam int DEF_COOLDOWN_CYCLES = 50_000_000;
   localparam int SHOT_COUNT_W        = 8;
endpackage

// File: rtl/fire_button_trigger_debounce_sync.sv
// debounce_sync: 2-FF synchronizer and debounce filter for an active-low button
//   clock, reset          : clock, synchronous active-high reset
//   button                : raw asynchronous level, 0 = pressed
//   stable                : debounced level, 1 = released
//   press_edge/release_edge : one-cycle strobes, registered together with the stable flip
module debounce_sync
   import fire_trigger_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
   input  logic clock,
   input  logic reset,
   input  logic button,
   output logic stable,
   output logic press_edge,
   output logic release_edge
);
   localparam int W = $clog2(DEBOUNCE_CYCLES + 1);
   logic s1, s2;
   logic [W-1:0] cnt;
   always_ff @(posedge clock) begin
      if (reset) begin
         s1           <= 1'b1;
         s2           <= 1'b1;
         stable       <= 1'b1;
         cnt          <= '0;
         press_edge   <= 1'b0;
         release_edge <= 1'b0;
      end else begin
         s1           <= button;
         s2           <= s1;
         press_edge   <= 1'b0;
         release_edge <= 1'b0;
         if (s2 == stable)
            cnt <= '0;
         // the DEBOUNCE_CYCLES-th consecutive differing sample flips the level
         else if (cnt == W'(DEBOUNCE_CYCLES - 1)) begin
            stable       <= s2;
            cnt          <= '0;
            press_edge   <= ~s2;
            release_edge <= s2;
         end else
            cnt <= cnt + 1'b1;
      end
   end
endmodule

// File: rtl/fire_button_trigger.sv
// fire_button_trigger: debounced fire button to one-cycle fire request with busy check and cooldown
//   clock, reset  : clock, synchronous active-high reset
//   button        : raw active-low fire button
//   shooter_busy  : shoot sequencer running
//   fire / drop   : one-cycle pulses (request issued / accepted press discarded)
//   pressed       : debounced level, active-high
//   armed         : high while a new press will be accepted
//   shot_count    : fire pulses modulo 256
// Optional: FIRE_TRIGGER_QUEUE_EN holds one press made while busy until the sequencer frees up.
module fire_button_trigger
   import fire_trigger_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int COOLDOWN_CYCLES = DEF_COOLDOWN_CYCLES
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    button,
   input  logic                    shooter_busy,
   output logic                    fire,
   output logic                    drop,
   output logic                    pressed,
   output logic                    armed,
   output logic [SHOT_COUNT_W-1:0] shot_count
);
   localparam int CW = $clog2(COOLDOWN_CYCLES + 1);
   state_t state;
   logic [CW-1:0] cd_cnt;
   logic stable, press_edge, release_edge;
   logic fire_d, drop_d;
   logic accept;
   debounce_sync #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
      .clock        (clock),
      .reset        (reset),
      .button       (button),
      .stable       (stable),
      .press_edge   (press_edge),
      .release_edge (release_edge)
   );
   assign pressed = ~stable;
   assign accept  = (state == IDLE) && press_edge;
`ifdef FIRE_TRIGGER_QUEUE_EN
   logic pending, pending_d;
   always_comb begin
      fire_d    = 1'b0;
      drop_d    = 1'b0;
      pending_d = pending;
      // a held request leaves on the first free cycle, regardless of FSM state
      if (pending && !shooter_busy) begin
         fire_d    = 1'b1;
         pending_d = 1'b0;
      end
      if (accept) begin
         if (pending)
            drop_d = 1'b1;
         else if (!shooter_busy)
            fire_d = 1'b1;
         else
            pending_d = 1'b1;
      end
   end
   always_ff @(posedge clock)
      pending <= reset ? 1'b0 : pending_d;
`else
   always_comb begin
      fire_d = accept && !shooter_busy;
      drop_d = accept && shooter_busy;
   end
`endif
   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= IDLE;
         cd_cnt     <= '0;
         fire       <= 1'b0;
         drop       <= 1'b0;
         armed      <= 1'b1;
         shot_count <= '0;
      end else begin
         fire       <= fire_d;
         drop       <= drop_d;
         shot_count <= shot_count + SHOT_COUNT_W'(fire_d);
         case (state)
            IDLE: if (press_edge) begin
               state <= PRESSED;
               armed <= 1'b0;
            end
            PRESSED: if (release_edge) begin
               state  <= COOLDOWN;
               cd_cnt <= '0;
            end
            COOLDOWN: if (cd_cnt == CW'(COOLDOWN_CYCLES - 1)) begin
               state <= IDLE;
               armed <= 1'b1;
            end else
               cd_cnt <= cd_cnt + 1'b1;
            default: begin
               state <= IDLE;
               armed <= 1'b1;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_fire_button_trigger.sv
// tb_fire_button_trigger: directed plus randomized checks of fire_button_trigger against a timeline model
module tb_fire_button_trigger;
   localparam int D = 4;
   localparam int C = 8;
   logic clock = 1'b0;
   logic reset = 1'b1;
   logic button = 1'b1;
   logic shooter_busy = 1'b0;
   logic fire, drop, pressed, armed;
   logic [7:0] shot_count;
   int vectors = 0, miscompares = 0, cyc = 0;
   int last_fire = -1, last_drop = -1, fires = 0, base = 0;
   bit m_idle, m_hold, m_pend, m_deb, m_ps, m_rs, m_fire, m_drop;
   int m_run, m_cool;
   bit [7:0] m_shots;
   bit pipe[$];

   always #5 clock = ~clock;

   fire_button_trigger #(.DEBOUNCE_CYCLES(D), .COOLDOWN_CYCLES(C)) dut (
      .clock        (clock),
      .reset        (reset),
      .button       (button),
      .shooter_busy (shooter_busy),
      .fire         (fire),
      .drop         (drop),
      .pressed      (pressed),
      .armed        (armed),
      .shot_count   (shot_count)
   );

   task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
      assert (got === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d at edge %0d", tag, got, exp, cyc);
      end
   endtask

   // behavioural model: button seen two edges late, debounced after D consecutive
   // differing samples, accepted press answered one edge later, re-arm C edges after release
   task automatic model_edge(bit r, bit b, bit busy);
      bit ps, rs, s2;
      ps = m_ps;
      rs = m_rs;
      if (r) begin
         m_idle = 1; m_hold = 0; m_cool = 0; m_pend = 0; m_fire = 0; m_drop = 0;
         m_shots = 0; m_deb = 1; m_run = 0; m_ps = 0; m_rs = 0;
         pipe = '{1'b1, 1'b1};
         return;
      end
      m_fire = 0;
      m_drop = 0;
`ifdef FIRE_TRIGGER_QUEUE_EN
      if (m_pend && !busy) begin
         m_fire = 1;
         m_pend = 0;
         if (m_idle && ps) m_drop = 1;
      end else if (m_idle && ps) begin
         if (m_pend) m_drop = 1;
         else if (!busy) m_fire = 1;
         else m_pend = 1;
      end
`else
      if (m_idle && ps) begin
         m_fire = !busy;
         m_drop = busy;
      end
`endif
      if (m_idle && ps) begin
         m_idle = 0;
         m_hold = 1;
      end else if (m_hold && rs) begin
         m_hold = 0;
         m_cool = C;
      end else if (m_cool > 0) begin
         m_cool--;
         if (m_cool == 0) m_idle = 1;
      end
      m_shots += 8'(m_fire);
      s2 = pipe.pop_front();
      pipe.push_back(b);
      m_ps = 0;
      m_rs = 0;
      if (s2 != m_deb) begin
         m_run++;
         if (m_run == D) begin
            m_deb = s2;
            m_run = 0;
            m_ps = !s2;
            m_rs = s2;
         end
      end else
         m_run = 0;
   endtask

   task automatic step(bit r, bit b, bit busy);
      reset = r;
      button = b;
      shooter_busy = busy;
      @(posedge clock);
      model_edge(r, b, busy);
      #1;
      vectors++;
      if (fire === 1'b1) begin
         last_fire = cyc;
         fires++;
      end
      if (drop === 1'b1) last_drop = cyc;
      check("fire", fire, m_fire);
      check("drop", drop, m_drop);
      check("pressed", pressed, !m_deb);
      check("armed", armed, m_idle);
      check("shot_count", shot_count, m_shots);
      cyc++;
   endtask

   task automatic hold(bit b, bit busy, int n);
      repeat (n) step(1'b0, b, busy);
   endtask

   initial begin
      int len;
      bit rb;
      // reset, then a long press with the sequencer idle
      step(1, 1, 0);
      step(1, 1, 0);
      check("rst_armed", armed, 1);
      check("rst_shots", shot_count, 0);
      fires = 0;
      base = cyc;
      hold(0, 0, 20);
      check("press_fire_edge", last_fire, base + D + 2);
      check("press_fire_count", fires, 1);
      check("press_shots", shot_count, 1);
      check("press_armed", armed, 0);
      hold(1, 0, 20);
      // short glitches never debounce
      step(1, 1, 0);
      fires = 0;
      repeat (5) begin
         hold(0, 0, 3);
         hold(1, 0, 5);
      end
      check("glitch_fires", fires, 0);
      check("glitch_pressed", pressed, 0);
      check("glitch_shots", shot_count, 0);
      // press while the sequencer is busy
      step(1, 1, 0);
      fires = 0;
      base = cyc;
`ifdef FIRE_TRIGGER_QUEUE_EN
      hold(0, 1, 15);
      hold(0, 0, 3);
      check("queued_fire_edge", last_fire, base + 15);
      check("queued_fire_count", fires, 1);
`else
      hold(0, 1, 12);
      check("busy_drop_edge", last_drop, base + D + 2);
      check("busy_fires", fires, 0);
`endif
      hold(1, 0, 25);
      // second press inside cooldown is ignored, press after re-arm fires
      step(1, 1, 0);
      fires = 0;
      hold(0, 0, 8);
      hold(1, 0, 6);
      hold(0, 0, 8);
      hold(1, 0, 25);
      check("cooldown_fires", fires, 1);
      hold(0, 0, 8);
      check("rearm_fires", fires, 2);
      check("rearm_shots", shot_count, 2);
      hold(1, 0, 25);
      // 256 accepted presses wrap the shot counter
      step(1, 1, 0);
      fires = 0;
      repeat (256) begin
         hold(0, 0, 7);
         hold(1, 0, 20);
      end
      check("wrap_fires", fires, 256);
      check("wrap_shots", shot_count, 0);
      // reset part-way through a debounce window
      step(1, 1, 0);
      fires = 0;
      hold(0, 0, 4);
      step(1, 0, 0);
      check("midrst_fire", fire, 0);
      check("midrst_armed", armed, 1);
      check("midrst_pressed", pressed, 0);
      step(0, 0, 0);
      check("midrst_next_fire", fire, 0);
      hold(0, 0, 12);
      check("midrst_refire", fires, 1);
      hold(1, 0, 25);
      // randomized levels, busy and occasional reset
      step(1, 1, 0);
      repeat (250) begin
         rb = 1'($urandom_range(0, 1));
         len = $urandom_range(1, 12);
         repeat (len) step(($urandom_range(0, 299) == 0), rb, ($urandom_range(0, 2) == 0));
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
